sort_engine_gen2: RTL
=====================

SORT_ENGINE_GEN2 -- requirements
Module: sort_engine_gen2

Interface
REQ-001 Parameter ELEM_NUM, default 8, number of elements sorted; SHALL be >= 2.
REQ-002 Parameter DATA_W, default 8, element width in bits; SHALL be >= 2.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begins a sort; sampled only in IDLE.
REQ-006 descend  in  1  1: largest first, 0: smallest first; sampled with start.
REQ-007 bit_data  in  ELEM_NUM  bit[bit_addr] of every element, combinational, valid in the same cycle bit_addr is driven.
REQ-008 bit_addr  out  clog2(DATA_W)  bit column requested, MSB first.
REQ-009 out_valid  out  1  out_addr holds the next sorted element index.
REQ-010 out_ready  in  1  consumer accepts out_addr when out_valid and out_ready are both high.
REQ-011 out_addr  out  clog2(ELEM_NUM)  element index.
REQ-012 out_last  out  1  qualifies out_valid; marks the final element of the sort.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 done  out  1  one-cycle pulse after the final handshake.

Function
REQ-015 FSM states: IDLE, SCAN, EMIT, DONE.
REQ-016 IDLE with start=1: load EVT = all ones, cand = all ones, bit_addr = DATA_W-1, latch descend, go to SCAN.
REQ-017 In SCAN, each cycle compute col = descend ? bit_data : ~bit_data and nxt = cand & col; if nxt == 0 then nxt = cand.
REQ-018 In SCAN, if bit_addr == 0 or nxt is one-hot: grp <= nxt, go to EMIT; otherwise cand <= nxt and bit_addr decrements.
REQ-019 In EMIT, out_valid = 1 and out_addr = lowest set index of grp, so ties emit in ascending index order (stable sort).
REQ-020 In EMIT, out_addr and out_last SHALL hold stable while out_ready = 0.
REQ-021 On each EMIT handshake, clear the emitted bit in both grp and EVT.
REQ-022 Handshake when grp becomes empty and EVT stays non-empty: go to SCAN with cand = updated EVT and bit_addr = DATA_W-1.
REQ-023 Handshake when EVT becomes empty: go to DONE; out_last SHALL be high on that handshake only.
REQ-024 DONE: done = 1 for one cycle, then return to IDLE.
REQ-025 start outside IDLE SHALL be ignored.
REQ-026 The first out_valid SHALL appear no later than DATA_W cycles after start is accepted.
REQ-027 Consecutive members of a tie group SHALL emit on consecutive cycles when out_ready = 1.
REQ-028 bit_addr SHALL stay at DATA_W-1 in IDLE, EMIT and DONE.

Reset
REQ-029 Reset values: bit_addr = DATA_W-1, out_valid = 0, out_addr = 0, out_last = 0, busy = 0, done = 0, EVT = all ones, state = IDLE.
REQ-030 rst asserted in any state SHALL abort the sort within one cycle; the pending output is discarded.

Configuration
REQ-031 With macro SORT_TOPK_EN defined, add input k (clog2(ELEM_NUM)+1 bits), sampled with start.
REQ-032 With SORT_TOPK_EN defined, the sort ends after k handshakes: out_last is high on the k-th handshake, then DONE; k = 0 or k > ELEM_NUM means ELEM_NUM.
REQ-033 With SORT_TOPK_EN undefined, port k is absent and all ELEM_NUM elements are emitted.

Verification (ELEM_NUM = 8, DATA_W = 8; data idx0..7 = {3, 7, 1, 7, 0, 5, 2, 6} unless stated)
REQ-034 descend = 1, out_ready = 1 -> out_addr sequence 1, 3, 7, 5, 0, 6, 2, 4; out_last with 4; done the next cycle.
REQ-035 descend = 0, out_ready = 1 -> out_addr sequence 4, 2, 6, 0, 5, 7, 1, 3; out_last with 3.
REQ-036 All elements 0x55 -> SCAN lasts 8 cycles (bit_addr 7..0), then out_addr 0..7 on 8 consecutive cycles.
REQ-037 descend = 1, out_ready = 0 for 3 cycles at the first out_valid -> out_valid stays 1 and out_addr stays 1 throughout, sequence otherwise unchanged.
REQ-038 rst during SCAN at bit_addr = 4 -> next cycle busy = 0, bit_addr = 7, out_valid = 0; a new start then reproduces REQ-034.
REQ-039 SORT_TOPK_EN defined, k = 3, descend = 1 -> out_addr 1, 3, 7; out_last with 7; done the next cycle.

Source files
------------

// File: rtl/sort_engine_gen2_if.sv
// Sort engine handshake bundle: sort control, bit-column fetch and output stream.
// Optional top-k input k is present when SORT_TOPK_EN is defined.
interface sort_engine_gen2_if #(
    parameter int ELEM_NUM = 8,
    parameter int DATA_W   = 8
);
    localparam int AW = $clog2(ELEM_NUM);
    localparam int BW = $clog2(DATA_W);

    logic                start;
    logic                descend;
    logic [ELEM_NUM-1:0] bit_data;
    logic [BW-1:0]       bit_addr;
    logic                out_valid;
    logic                out_ready;
    logic [AW-1:0]       out_addr;
    logic                out_last;
    logic                busy;
    logic                done;
`ifdef SORT_TOPK_EN
    logic [AW:0]         k;

    modport master (
        output start, descend, bit_data, out_ready, k,
        input  bit_addr, out_valid, out_addr, out_last, busy, done
    );
    modport slave (
        input  start, descend, bit_data, out_ready, k,
        output bit_addr, out_valid, out_addr, out_last, busy, done
    );
`else
    modport master (
        output start, descend, bit_data, out_ready,
        input  bit_addr, out_valid, out_addr, out_last, busy, done
    );
    modport slave (
        input  start, descend, bit_data, out_ready,
        output bit_addr, out_valid, out_addr, out_last, busy, done
    );
`endif
endinterface

// File: rtl/sort_engine_gen2.sv
// Bit-serial MSB-first radix sort engine; emits element indices in sorted, stable order.
// Define SORT_TOPK_EN to add input k and stop after the first k elements.
module sort_engine_gen2 #(
    parameter int ELEM_NUM = 8,
    parameter int DATA_W   = 8
) (
    input logic               clk,
    input logic               rst,
    sort_engine_gen2_if.slave bus
);
    localparam int AW = $clog2(ELEM_NUM);
    localparam int BW = $clog2(DATA_W);
    localparam int CW = AW + 1;
    localparam logic [BW-1:0] BIT_TOP = BW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t              state_q, state_d;
    logic [ELEM_NUM-1:0] evt_q, evt_d;
    logic [ELEM_NUM-1:0] cand_q, cand_d;
    logic [ELEM_NUM-1:0] grp_q, grp_d;
    logic [BW-1:0]       bit_addr_q, bit_addr_d;
    logic                desc_q, desc_d;
    logic                out_valid_q, out_valid_d;
    logic [AW-1:0]       out_addr_q, out_addr_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [ELEM_NUM-1:0] col, nxt, sel, evt_nx, grp_nx;
    logic                hs, last_scan, last_emit;

`ifdef SORT_TOPK_EN
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       k_q, k_d;
    logic [CW-1:0]       k_eff;
`endif

    function automatic logic [AW-1:0] lowest(input logic [ELEM_NUM-1:0] v);
        lowest = '0;
        for (int i = ELEM_NUM - 1; i >= 0; i--) begin
            if (v[i]) lowest = AW'(i);
        end
    endfunction

    // Decide if the element about to be presented is the final one of the sort
    always_comb begin
`ifdef SORT_TOPK_EN
        k_eff     = (k_q == '0 || k_q > CW'(ELEM_NUM)) ? CW'(ELEM_NUM) : k_q;
        last_scan = (cnt_q + CW'(1)) == k_eff;
        last_emit = (cnt_q + CW'(2)) == k_eff;
`else
        last_scan = $onehot(evt_q);
        last_emit = $onehot(evt_nx);
`endif
    end

    // Next-state logic: column scan narrowing, group emission, evt bookkeeping
    always_comb begin
        state_d     = state_q;
        evt_d       = evt_q;
        cand_d      = cand_q;
        grp_d       = grp_q;
        bit_addr_d  = bit_addr_q;
        desc_d      = desc_q;
        out_valid_d = out_valid_q;
        out_addr_d  = out_addr_q;
        out_last_d  = out_last_q;
`ifdef SORT_TOPK_EN
        cnt_d       = cnt_q;
        k_d         = k_q;
`endif
        col    = desc_q ? bus.bit_data : ~bus.bit_data;
        nxt    = cand_q & col;
        if (nxt == '0) nxt = cand_q;
        sel    = ELEM_NUM'(1) << out_addr_q;
        evt_nx = evt_q & ~sel;
        grp_nx = grp_q & ~sel;
        hs     = (state_q == EMIT) && bus.out_ready;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    evt_d      = '1;
                    cand_d     = '1;
                    bit_addr_d = BIT_TOP;
                    desc_d     = bus.descend;
                    state_d    = SCAN;
`ifdef SORT_TOPK_EN
                    cnt_d      = '0;
                    k_d        = bus.k;
`endif
                end
            end
            SCAN: begin
                if (bit_addr_q == '0 || $onehot(nxt)) begin
                    grp_d       = nxt;
                    bit_addr_d  = BIT_TOP;
                    state_d     = EMIT;
                    out_valid_d = 1'b1;
                    out_addr_d  = lowest(nxt);
                    out_last_d  = last_scan;
                end else begin
                    cand_d     = nxt;
                    bit_addr_d = bit_addr_q - BW'(1);
                end
            end
            EMIT: begin
                if (hs) begin
                    grp_d = grp_nx;
                    evt_d = evt_nx;
`ifdef SORT_TOPK_EN
                    cnt_d = cnt_q + CW'(1);
`endif
                    if (out_last_q) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else if (grp_nx == '0) begin
                        state_d     = SCAN;
                        cand_d      = evt_nx;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_addr_d = lowest(grp_nx);
                        out_last_d = last_emit;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State and registered outputs, synchronous reset aborts any sort in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            evt_q       <= '1;
            cand_q      <= '0;
            grp_q       <= '0;
            bit_addr_q  <= BIT_TOP;
            desc_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SORT_TOPK_EN
            cnt_q       <= '0;
            k_q         <= '0;
`endif
        end else begin
            state_q     <= state_d;
            evt_q       <= evt_d;
            cand_q      <= cand_d;
            grp_q       <= grp_d;
            bit_addr_q  <= bit_addr_d;
            desc_q      <= desc_d;
            out_valid_q <= out_valid_d;
            out_addr_q  <= out_addr_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef SORT_TOPK_EN
            cnt_q       <= cnt_d;
            k_q         <= k_d;
`endif
        end
    end

    assign bus.bit_addr  = bit_addr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
endmodule
